// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache side owns the memory port
//   op_t        : latched memory operation
//   arb_pick()  : round-robin tie-break between the two cache sides
package cacheline_arbiter_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Single requester wins outright; on a tie the side that did not win
    // last time is chosen. Result is don't-care when nobody requests.
    function automatic owner_t arb_pick(input logic   i_req,
                                        input logic   d_req,
                                        input owner_t last_grant);
        owner_t pick;
        if (i_req && d_req) begin
            pick = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            pick = OWN_D;
        end else begin
            pick = OWN_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Two-to-one arbiter placing an I-cache and a D-cache in front of a single
// cacheline memory port. One transfer is in flight at a time; the owner's
// address, op and write data are captured at grant so the requester may
// change its inputs while memory is busy.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_read, i_addr            I-cache fill request (held until i_resp)
//   i_rdata, i_resp           I-cache fill data and one-cycle completion
//   d_read, d_write, d_addr,  D-cache fill / writeback request (held until
//   d_wdata                   d_resp); write wins if both are high
//   d_rdata, d_resp           D-cache fill data and one-cycle completion
//   mem_read, mem_write,      memory-side request, held from the cycle after
//   mem_addr, mem_wdata       grant through the mem_resp cycle
//   mem_rdata, mem_resp       memory return data and completion pulse
//   i_grant_cnt, d_grant_cnt  wrapping grant counters per side
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transfer; arbitrate between i_read and d_read/d_write
// I_BUSY  | I-cache fill on the memory port, waiting for mem_resp
// D_BUSY  | D-cache fill or writeback on the memory port
// RESP    | owner's resp pulse is high; back to IDLE next cycle
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_t        r_state;
    owner_t            r_owner;
    owner_t            r_last_grant;
    op_t               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [CNT_W-1:0]  r_i_grant_cnt;
    logic [CNT_W-1:0]  r_d_grant_cnt;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_any_req;
    owner_t            w_winner;
    op_t               w_grant_op;
    logic [ADDR_W-1:0] w_grant_addr;

    assign w_i_req      = i_read;
    assign w_d_req      = d_read | d_write;
    assign w_any_req    = w_i_req | w_d_req;
    assign w_winner     = arb_pick(w_i_req, w_d_req, r_last_grant);
    // A D-side request with both strobes high is treated as a writeback; the
    // fill is picked up when the cache re-requests after d_resp.
    assign w_grant_op   = ((w_winner == OWN_D) && d_write) ? OP_WRITE : OP_READ;
    assign w_grant_addr = (w_winner == OWN_D) ? d_addr : i_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_I;
            r_last_grant  <= OWN_I;
            r_op          <= OP_READ;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_i_resp      <= 1'b0;
            r_d_resp      <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_i_grant_cnt <= '0;
            r_d_grant_cnt <= '0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_op         <= w_grant_op;
                        r_addr       <= w_grant_addr;
                        r_wdata      <= d_wdata;
                        r_mem_read   <= (w_grant_op == OP_READ);
                        r_mem_write  <= (w_grant_op == OP_WRITE);
                        if (w_winner == OWN_D) begin
                            r_state       <= ST_D_BUSY;
                            r_d_grant_cnt <= r_d_grant_cnt + CNT_W'(1);
                        end else begin
                            r_state       <= ST_I_BUSY;
                            r_i_grant_cnt <= r_i_grant_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_I_BUSY, ST_D_BUSY: begin
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_RESP;
                        // Response pulse is raised on the same edge the
                        // data is captured so it lines up with the RESP cycle.
                        if (r_owner == OWN_D) begin
                            r_d_resp <= 1'b1;
                            if (r_op == OP_READ) begin
                                r_d_rdata <= mem_rdata;
                            end
                        end else begin
                            r_i_resp <= 1'b1;
                            if (r_op == OP_READ) begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata     = r_i_rdata;
    assign i_resp      = r_i_resp;
    assign d_rdata     = r_d_rdata;
    assign d_resp      = r_d_resp;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_grant_cnt = r_i_grant_cnt;
    assign d_grant_cnt = r_d_grant_cnt;

endmodule
